// File: rtl/led_walk_sequencer_pkg.sv
// Shared definitions for the walking-LED sequencer: command op codes, FSM states
// and the bounce-position to one-hot LED mapping.
package led_seq_pkg;

  localparam logic [1:0] OP_STOP       = 2'b00;
  localparam logic [1:0] OP_START      = 2'b01;
  localparam logic [1:0] OP_PAUSE      = 2'b10;
  localparam logic [1:0] OP_SET_PERIOD = 2'b11;

  localparam int LED_MAX = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  // Positions past the last LED fold back so the sweep bounces off the far end.
  function automatic logic [LED_MAX-1:0] pos_to_led(input int pos, input int nleds);
    logic [LED_MAX-1:0] one;
    int                 idx;
    one    = '0;
    one[0] = 1'b1;
    idx    = (pos < nleds) ? pos : (2 * nleds - 2 - pos);
    return one << idx;
  endfunction

endpackage

// File: rtl/led_walk_sequencer_step_timer.sv
// Loadable down-counter: counts while enabled, flags expiry at zero and reloads.
// A load request takes priority over the reload of the same cycle.
module led_step_timer #(
  parameter int               CNT_W     = 32,
  parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] reload_val,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  assign expire = en && (count == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= RESET_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= expire ? reload_val : (count - CNT_W'(1));
    end
  end

endmodule

// File: rtl/led_walk_sequencer.sv
// Walking-LED run-time controller: command handshake, IDLE/RUN/PAUSE FSM, step timer,
// bounce position and LED register. Optional pause blinking via LED_SEQ_BLINK_EN.
module led_walk_sequencer
  import led_seq_pkg::*;
#(
  parameter  int NLEDS       = 8,
  parameter  int CLK_RATE_HZ = 1000,
  parameter  int CNT_W       = 32,
  localparam int PW          = $clog2(2 * NLEDS - 2)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic [CNT_W-1:0] i_cmd_data,
  output logic [NLEDS-1:0] o_led,
  output logic [PW-1:0]    o_pos,
  output logic             o_stb,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(CLK_RATE_HZ - 1);
  localparam logic [PW-1:0]    POS_LAST   = PW'(2 * NLEDS - 3);

  state_t           state, state_next;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] load_val;
  logic [NLEDS-1:0] pattern;
  logic             accept, is_stop, is_start, is_pause, is_setp;
  logic             timer_en, timer_load, expire, step;
`ifdef LED_SEQ_BLINK_EN
  logic             blink_tgl;
`endif

  assign accept   = i_cmd_valid && o_cmd_ready;
  assign is_stop  = accept && (i_cmd_op == OP_STOP);
  assign is_start = accept && (i_cmd_op == OP_START);
  assign is_pause = accept && (i_cmd_op == OP_PAUSE);
  assign is_setp  = accept && (i_cmd_op == OP_SET_PERIOD);
  assign o_busy   = (state != S_IDLE);
  assign pattern  = NLEDS'(pos_to_led(int'(o_pos), NLEDS));

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state <= S_IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (is_start) state_next = S_RUN;
      S_RUN:   if (is_pause) state_next = S_PAUSE;
               else if (is_stop) state_next = S_IDLE;
      S_PAUSE: if (is_start) state_next = S_RUN;
               else if (is_stop) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Timer control; a STOP or PAUSE landing on an expiry swallows that step.
  always_comb begin
    timer_load = 1'b0;
    load_val   = period;
`ifdef LED_SEQ_BLINK_EN
    timer_en   = (state == S_RUN) || (state == S_PAUSE);
    blink_tgl  = expire && (state == S_PAUSE);
`else
    timer_en   = (state == S_RUN);
`endif
    if (is_setp) begin
      timer_load = 1'b1;
      load_val   = i_cmd_data;
    end else if (is_stop) begin
      timer_load = 1'b1;
    end else if (is_start && (state == S_IDLE)) begin
      timer_load = 1'b1;
`ifdef LED_SEQ_BLINK_EN
    end else if (is_start && (state == S_PAUSE)) begin
      timer_load = 1'b1;
`endif
    end
    step = expire && (state == S_RUN) && !is_stop && !is_pause;
  end

  led_step_timer #(
    .CNT_W     (CNT_W),
    .RESET_VAL (PERIOD_RST)
  ) u_timer (
    .clk        (i_clk),
    .reset_n    (i_reset_n),
    .en         (timer_en),
    .load       (timer_load),
    .load_val   (load_val),
    .reload_val (period),
    .expire     (expire)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      period      <= PERIOD_RST;
      o_pos       <= '0;
      o_led       <= NLEDS'(1);
      o_stb       <= 1'b0;
      o_cmd_ready <= 1'b1;
    end else begin
      o_cmd_ready <= !accept;
      o_stb       <= step;
      if (is_setp) period <= i_cmd_data;

      if (is_stop)   o_pos <= '0;
      else if (step) o_pos <= (o_pos == POS_LAST) ? '0 : (o_pos + PW'(1));

      // LED follows the position one clock later; STOP snaps it home directly.
      if (is_stop)
        o_led <= NLEDS'(1);
`ifdef LED_SEQ_BLINK_EN
      else if (is_start && (state == S_PAUSE))
        o_led <= pattern;
      else if (blink_tgl)
        o_led <= (o_led == '0) ? pattern : '0;
      else if (state != S_PAUSE)
        o_led <= pattern;
`else
      else
        o_led <= pattern;
`endif
    end
  end

endmodule

// File: tb/tb_led_walk_sequencer.sv
// Directed bench for led_walk_sequencer (NLEDS=8, reset period 5); step events are
// checked against a queue of expected position/LED/interval entries.
module tb_led_walk_sequencer;

  typedef struct {
    int pos;
    int led;
    int gap;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_data;
  logic [7:0]  led;
  logic [3:0]  pos;
  logic        stb;
  logic        busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_ref = 0;
  exp_t sb[$];
  int   led_tab[14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                        8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};

  led_walk_sequencer #(
    .NLEDS       (8),
    .CLK_RATE_HZ (6),
    .CNT_W       (32)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_op    (cmd_op),
    .i_cmd_data  (cmd_data),
    .o_led       (led),
    .o_pos       (pos),
    .o_stb       (stb),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] data);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_stb();
    exp_t e;
    int   n = 0;
    e = sb.pop_front();
    while (stb !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    check("stb_seen", 32'(stb), 32'd1);
    check("stb_gap", cyc - last_ref, e.gap);
    check("stb_pos", 32'(pos), e.pos);
    last_ref = cyc;
    tick();
    check("led_after_stb", 32'(led), e.led);
    check("stb_width", 32'(stb), 32'd0);
  endtask

  initial begin
    int seen;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = '0;
    repeat (3) tick();
    check("rst_pos", 32'(pos), 32'd0);
    check("rst_led", 32'(led), 32'h01);
    check("rst_stb", 32'(stb), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    reset_n = 1'b1;
    tick();

    // Period 3: one step every 4 clocks, full bounce and on to position 5.
    send(2'b11, 32'd3);
    check("setp_ready_drop", 32'(cmd_ready), 32'd0);
    tick();
    send(2'b01, 32'd0);
    last_ref = cyc;
    check("start_busy", 32'(busy), 32'd1);
    for (int i = 1; i <= 19; i++) sb.push_back('{i % 14, led_tab[i % 14], 4});
    for (int i = 0; i < 19; i++) wait_stb();

    // Pause at position 5 with the counter at 1 remaining after the accept edge.
    send(2'b10, 32'd0);
    for (int i = 0; i < 20; i++) begin
      check("pause_pos", 32'(pos), 32'd5);
`ifdef LED_SEQ_BLINK_EN
      check("pause_blink_led", 32'(led), (((i + 2) / 4) % 2 == 1) ? 32'h00 : 32'h20);
`else
      check("pause_led", 32'(led), 32'h20);
`endif
      tick();
    end
    check("pause_busy", 32'(busy), 32'd1);
    send(2'b01, 32'd0);
    last_ref = cyc;
`ifdef LED_SEQ_BLINK_EN
    sb.push_back('{6, 32'h40, 4});
`else
    sb.push_back('{6, 32'h40, 2});
`endif
    wait_stb();

    // Back-to-back: START (ignored in RUN), then SET_PERIOD 0 landing on an expiry.
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_data  = 32'd0;
    tick();
    check("b2b_ready_low", 32'(cmd_ready), 32'd0);
    check("start_in_run_pos", 32'(pos), 32'd6);
    cmd_op = 2'b11;
    tick();
    check("b2b_ready_back", 32'(cmd_ready), 32'd1);
    check("b2b_no_step_yet", 32'(stb), 32'd0);
    tick();
    cmd_valid = 1'b0;
    check("setp_expiry_stb", 32'(stb), 32'd1);
    check("setp_expiry_pos", 32'(pos), 32'd7);
    check("b2b_second_accept", 32'(cmd_ready), 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("p0_stb", 32'(stb), 32'd1);
      check("p0_pos", 32'(pos), 32'(8 + k));
      check("p0_led", 32'(led), led_tab[7 + k]);
    end

    // One-clock reset at position 9, with a START presented during reset.
    reset_n   = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    tick();
    check("mid_rst_pos", 32'(pos), 32'd0);
    check("mid_rst_led", 32'(led), 32'h01);
    check("mid_rst_stb", 32'(stb), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    reset_n   = 1'b1;
    cmd_valid = 1'b0;
    tick();
    check("rst_cmd_dropped", 32'(busy), 32'd0);

    // Reset period (5) restored; then STOP issued on the expiry cycle.
    send(2'b01, 32'd0);
    last_ref = cyc;
    sb.push_back('{1, 32'h02, 6});
    wait_stb();
    repeat (4) tick();
    send(2'b00, 32'd0);
    check("stop_exp_stb", 32'(stb), 32'd0);
    check("stop_exp_pos", 32'(pos), 32'd0);
    check("stop_exp_led", 32'(led), 32'h01);
    check("stop_exp_busy", 32'(busy), 32'd0);
    seen = 0;
    repeat (10) begin
      tick();
      if (stb === 1'b1) seen++;
    end
    check("stop_quiet", seen, 32'd0);
    check("stop_hold_pos", 32'(pos), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
